// File: rtl/apb_event_responder.sv
// APB completer terminating event-notification writes for windows A/B/C with
// per-window saturating counters and last-data registers. Optional error response: APB_EVENT_RESPONDER_SLVERR_EN.
module apb_event_responder #(
    parameter int WAIT_CYCLES = 0,
    parameter int COUNT_W     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    input  logic [31:0] apb_paddr_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o,
    output logic        event_a_o,
    output logic        event_b_o,
    output logic        event_c_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0]         WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic               capture;
    logic               count_down;
    logic               complete;

    logic [31:0]        addr_q;
    logic               write_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wait_cnt;

    logic [COUNT_W-1:0] cnt [3];
    logic [31:0]        last [3];

    logic               pready_q;
    logic [31:0]        prdata_q;
    logic [2:0]         event_q;

    logic [2:0]         sel;
    logic               is_evt;
    logic               is_cnt;
    logic               is_last;
    logic [31:0]        rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        count_down = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (apb_psel_i && !apb_penable_i) begin
                    capture    = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb_psel_i) begin
                    state_next = IDLE;
                end else if (wait_cnt != 4'd0) begin
                    count_down = 1'b1;
                end else if (apb_penable_i) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Decode always works on the address captured in the setup phase.
    always_comb begin
        sel[0]  = (addr_q[31:16] == 16'hABBA);
        sel[1]  = (addr_q[31:16] == 16'hBAFF);
        sel[2]  = (addr_q[31:16] == 16'hCAFE);
        is_evt  = (addr_q[15:0] == 16'h0000);
        is_cnt  = (addr_q[15:0] == 16'h0004);
        is_last = (addr_q[15:0] == 16'h0008);
        rd_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (sel[i] && is_cnt) begin
                rd_data = 32'(cnt[i]);
            end else if (sel[i] && is_last) begin
                rd_data = last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
            event_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i]  <= '0;
                last[i] <= '0;
            end
        end else begin
            pready_q <= complete;
            event_q  <= '0;
            if (capture) begin
                addr_q   <= apb_paddr_i;
                write_q  <= apb_pwrite_i;
                wdata_q  <= apb_pwdata_i;
                wait_cnt <= WAIT_LOAD;
            end
            if (count_down) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (complete) begin
                if (!write_q) begin
                    prdata_q <= rd_data;
                end
                // Side effects land with pready, so they are visible in DONE.
                for (int i = 0; i < 3; i++) begin
                    if (sel[i] && write_q && is_evt) begin
                        if (cnt[i] != CNT_MAX) begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                        last[i]    <= wdata_q;
                        event_q[i] <= 1'b1;
                    end else if (sel[i] && write_q && is_cnt) begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

`ifdef APB_EVENT_RESPONDER_SLVERR_EN
    logic err;
    logic pslverr_q;

    assign err = !(|sel) || !(is_evt || is_cnt || is_last)
               || (is_evt && !write_q) || (is_last && write_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= complete && err;
        end
    end

    assign apb_pslverr_o = pslverr_q;
`else
    assign apb_pslverr_o = 1'b0;
`endif

    assign apb_pready_o = pready_q;
    assign apb_prdata_o = prdata_q;
    assign event_a_o    = event_q[0];
    assign event_b_o    = event_q[1];
    assign event_c_o    = event_q[2];

endmodule

// File: tb/tb_apb_event_responder.sv
// Bench for apb_event_responder: two instances (WAIT_CYCLES 0 and 3) share one APB bus
// and are checked every cycle against a transaction-level model.
module tb_apb_event_responder;

`ifdef APB_EVENT_RESPONDER_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif
    localparam int CNT_MAX = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;

    logic [1:0]  pready_v;
    logic [1:0]  pslverr_v;
    logic [5:0]  ev_v;
    logic [63:0] prdata_v;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          checking = 1'b0;
    bit          rst_at_edge = 1'b0;

    int          exp_rdy [2] = '{-1, -1};
    logic [2:0]  exp_evt = '0;
    bit          exp_err = 1'b0;
    bit          exp_rd = 1'b0;
    logic [31:0] exp_prd = '0;
    logic [31:0] hold_prd [2] = '{32'h0, 32'h0};

    int          cnt_m [3] = '{0, 0, 0};
    logic [31:0] last_m [3] = '{32'h0, 32'h0, 32'h0};

    logic [2:0]  seen_ev0;
    logic [2:0]  seen_ev3;
    logic        seen_err0;

    apb_event_responder #(.WAIT_CYCLES(0), .COUNT_W(8)) dut0 (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready_v[0]), .apb_prdata_o(prdata_v[31:0]),
        .apb_pslverr_o(pslverr_v[0]),
        .event_a_o(ev_v[0]), .event_b_o(ev_v[1]), .event_c_o(ev_v[2])
    );

    apb_event_responder #(.WAIT_CYCLES(3), .COUNT_W(8)) dut3 (
        .clk(clk), .reset(reset),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready_v[1]), .apb_prdata_o(prdata_v[63:32]),
        .apb_pslverr_o(pslverr_v[1]),
        .event_a_o(ev_v[3]), .event_b_o(ev_v[4]), .event_c_o(ev_v[5])
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !reset;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int winOf(input logic [31:0] a);
        case (a[31:16])
            16'hABBA: return 0;
            16'hBAFF: return 1;
            16'hCAFE: return 2;
            default:  return -1;
        endcase
    endfunction

    function automatic int regOf(input logic [31:0] a);
        case (a[15:0])
            16'h0000: return 0;
            16'h0004: return 4;
            16'h0008: return 8;
            default:  return -1;
        endcase
    endfunction

    // Every cycle: a DUT is in its completion cycle exactly at setup + 2 + WAIT_CYCLES.
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                bit done;
                done = (cyc == exp_rdy[d]);
                if (rst_at_edge) hold_prd[d] = '0;
                if (done && exp_rd) hold_prd[d] = exp_prd;
                checkOutput($sformatf("pready[%0d]", d), 32'(pready_v[d]), 32'(done));
                checkOutput($sformatf("events[%0d]", d), 32'(ev_v[d*3 +: 3]),
                            done ? 32'(exp_evt) : 32'h0);
                checkOutput($sformatf("pslverr[%0d]", d), 32'(pslverr_v[d]),
                            32'(done && exp_err && SLV));
                checkOutput($sformatf("prdata[%0d]", d), prdata_v[d*32 +: 32], hold_prd[d]);
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int c0, w, r, seen0, seen3;
        bit mapped;
        @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        c0 = cyc;
        w = winOf(addr);
        r = regOf(addr);
        mapped = (w >= 0) && (r >= 0);
        exp_evt = '0;
        exp_prd = '0;
        exp_rd  = !wr;
        exp_err = !mapped || (r == 0 && !wr) || (r == 8 && wr);
        if (mapped && !wr && r == 4) exp_prd = 32'(cnt_m[w]);
        if (mapped && !wr && r == 8) exp_prd = last_m[w];
        if (mapped && wr && r == 0) begin
            cnt_m[w]   = (cnt_m[w] < CNT_MAX) ? cnt_m[w] + 1 : CNT_MAX;
            last_m[w]  = data;
            exp_evt[w] = 1'b1;
        end
        if (mapped && wr && r == 4) cnt_m[w] = 0;
        exp_rdy[0] = c0 + 2;
        exp_rdy[1] = c0 + 5;
        @(posedge clk);
        #1;
        penable = 1'b1;
        seen0 = -1;
        seen3 = -1;
        for (int k = 0; k < 20 && seen3 < 0; k++) begin
            @(negedge clk);
            if (pready_v[0] && seen0 < 0) begin
                seen0     = cyc - c0;
                seen_ev0  = ev_v[2:0];
                seen_err0 = pslverr_v[0];
            end
            if (pready_v[1]) begin
                seen3    = cyc - c0;
                seen_ev3 = ev_v[5:3];
            end
        end
        checkOutput("latency_w0", 32'(seen0), 32'd2);
        checkOutput("latency_w3", 32'(seen3), 32'd5);
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        seen_ev0  = '0;
        seen_ev3  = '0;
        seen_err0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] reset state and initial counter reads");
        applyStimulus(1'b0, 32'hABBA_0004, '0);
        checkOutput("cnt_a_init", prdata_v[31:0], 32'h0);
        applyStimulus(1'b0, 32'hBAFF_0004, '0);
        checkOutput("cnt_b_init", prdata_v[63:32], 32'h0);
        applyStimulus(1'b0, 32'hCAFE_0004, '0);
        checkOutput("cnt_c_init", prdata_v[31:0], 32'h0);

        $display("[TB] event write to window A");
        applyStimulus(1'b1, 32'hABBA_0000, 32'h3);
        checkOutput("evt_a_pulse", 32'(seen_ev0), 32'h1);
        applyStimulus(1'b0, 32'hABBA_0004, '0);
        checkOutput("cnt_a_one", prdata_v[31:0], 32'h1);
        applyStimulus(1'b0, 32'hABBA_0008, '0);
        checkOutput("last_a", prdata_v[63:32], 32'h3);

        $display("[TB] event write to window C");
        applyStimulus(1'b1, 32'hCAFE_0000, 32'hDEAD_BEEF);
        checkOutput("evt_c_pulse", 32'(seen_ev3), 32'h4);
        applyStimulus(1'b0, 32'hBAFF_0004, '0);
        checkOutput("cnt_b_untouched", prdata_v[63:32], 32'h0);
        applyStimulus(1'b0, 32'hABBA_0004, '0);
        checkOutput("cnt_a_untouched", prdata_v[63:32], 32'h1);

        $display("[TB] saturation and clear on window B");
        for (int i = 0; i < 257; i++) applyStimulus(1'b1, 32'hBAFF_0000, 32'(i));
        applyStimulus(1'b0, 32'hBAFF_0004, '0);
        checkOutput("cnt_b_sat", prdata_v[31:0], 32'hFF);
        applyStimulus(1'b0, 32'hBAFF_0008, '0);
        checkOutput("last_b", prdata_v[31:0], 32'h100);
        applyStimulus(1'b1, 32'hBAFF_0004, 32'h1234_5678);
        applyStimulus(1'b0, 32'hBAFF_0004, '0);
        checkOutput("cnt_b_clear", prdata_v[63:32], 32'h0);

        $display("[TB] unmapped and error-class accesses");
        applyStimulus(1'b1, 32'h1234_0000, 32'h55);
        checkOutput("unmapped_evt", 32'(seen_ev0), 32'h0);
        checkOutput("unmapped_err", 32'(seen_err0), 32'(SLV));
        applyStimulus(1'b0, 32'hABBA_0000, '0);
        checkOutput("evt_read_err", 32'(seen_err0), 32'(SLV));
        checkOutput("evt_read_data", prdata_v[31:0], 32'h0);
        applyStimulus(1'b1, 32'hABBA_0008, 32'hFFFF_FFFF);
        checkOutput("last_write_err", 32'(seen_err0), 32'(SLV));
        applyStimulus(1'b0, 32'hABBA_0008, '0);
        checkOutput("last_a_kept", prdata_v[31:0], 32'h3);
        applyStimulus(1'b0, 32'hABBA_000C, '0);
        checkOutput("bad_offset_read", prdata_v[31:0], 32'h0);
        applyStimulus(1'b0, 32'hABBA_0004, '0);
        checkOutput("cnt_a_after_unmapped", prdata_v[31:0], 32'h1);

        $display("[TB] reset during access phase");
        @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hABBA_0000; pwdata = 32'h77;
        exp_rdy[0] = -1;
        exp_rdy[1] = -1;
        @(posedge clk);
        #1;
        penable = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cnt_m[i]  = 0;
            last_m[i] = '0;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        psel = 1'b0;
        penable = 1'b0;
        repeat (4) @(posedge clk);
        applyStimulus(1'b0, 32'hABBA_0004, '0);
        checkOutput("cnt_a_after_abort", prdata_v[63:32], 32'h0);
        applyStimulus(1'b0, 32'hABBA_0008, '0);
        checkOutput("last_a_after_abort", prdata_v[31:0], 32'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
